// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide execute unit: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product.
module ex_muldiv #(
  parameter int XLEN             = 32,
  parameter bit SPECIAL_FASTPATH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [31:0]     inst_addr_i,
  input  logic [XLEN-1:0] op_num1_i,
  input  logic [XLEN-1:0] op_num2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  output logic            hold_flag_o,
  output logic            busy_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o
);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;

  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [4:0]        cnt;
  logic [2*XLEN-1:0] mcand, acc;
  logic [XLEN-1:0]   mplier, dvd, rem, dvsr;
  logic              neg_res, neg_rem;

  // decode and operand conditioning for the start cycle
  logic [2:0]      f3_in;
  logic            is_md, start, s1, s2, n1, n2, div0, ovf;
  logic [XLEN-1:0] a1, a2, fast_res;
  assign f3_in = inst_i[14:12];
  assign is_md = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001) && reg_wen_i;
  assign start = (state == IDLE) && is_md;
  assign s1    = (f3_in == 3'd1) || (f3_in == 3'd2) || (f3_in == 3'd4) || (f3_in == 3'd6);
  assign s2    = (f3_in == 3'd1) || (f3_in == 3'd4) || (f3_in == 3'd6);
  assign n1    = s1 && op_num1_i[XLEN-1];
  assign n2    = s2 && op_num2_i[XLEN-1];
  assign a1    = n1 ? -op_num1_i : op_num1_i;
  assign a2    = n2 ? -op_num2_i : op_num2_i;
  assign div0  = (op_num2_i == '0);
  assign ovf   = s1 && f3_in[2] && (op_num1_i == SMIN) && (op_num2_i == '1);
  assign fast_res = f3_in[1] ? (div0 ? op_num1_i : '0) : (div0 ? '1 : SMIN);

  logic unused_dbg;
  assign unused_dbg = ^{inst_addr_i, inst_i[24:15], inst_i[11:7]};

  // one iteration step of each datapath
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     sh, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nxt, dvd_nxt;
  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign sh      = {rem, dvd[XLEN-1]};
  assign diff    = sh - {1'b0, dvsr};
  assign ge      = ~diff[XLEN];
  assign rem_nxt = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
  assign dvd_nxt = {dvd[XLEN-2:0], ge};

  function automatic logic [XLEN-1:0] fix_res(input logic [2:0] f, input logic [2*XLEN-1:0] pm,
                                              input logic [XLEN-1:0] qm, rm, input logic nr, ne);
    logic [2*XLEN-1:0] p;
    p = nr ? -pm : pm;
    if (f == 3'd0)   fix_res = p[XLEN-1:0];
    else if (!f[2])  fix_res = p[2*XLEN-1:XLEN];
    else if (!f[1])  fix_res = nr ? -qm : qm;
    else             fix_res = ne ? -rm : rm;
  endfunction

  assign hold_flag_o = start || (state == MUL) || (state == DIV);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; f3_q <= '0; rd_q <= '0; cnt <= '0;
      mcand <= '0; acc <= '0; mplier <= '0; dvd <= '0; rem <= '0; dvsr <= '0;
      neg_res <= 1'b0; neg_rem <= 1'b0;
      rd_addr_o <= '0; rd_data_o <= '0; rd_wen_o <= 1'b0;
    end else begin
      rd_wen_o <= 1'b0;
      case (state)
        IDLE: if (is_md) begin
          f3_q    <= f3_in;
          rd_q    <= rd_addr_i;
          cnt     <= '0;
          neg_res <= f3_in[2] ? ((n1 ^ n2) & ~div0) : (n1 ^ n2);
          neg_rem <= n1;
          if (f3_in[2]) begin
            if (SPECIAL_FASTPATH && (div0 || ovf)) begin
              rd_data_o <= fast_res;
              rd_addr_o <= rd_addr_i;
              rd_wen_o  <= 1'b1;
              state     <= DONE;
            end else begin
              dvd <= a1; rem <= '0; dvsr <= a2;
              state <= DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            rd_data_o <= fix_res(f3_in, (2*XLEN)'(a1) * (2*XLEN)'(a2), '0, '0, n1 ^ n2, 1'b0);
            rd_addr_o <= rd_addr_i;
            rd_wen_o  <= 1'b1;
            state     <= DONE;
`else
            mcand <= {{XLEN{1'b0}}, a1}; mplier <= a2; acc <= '0;
            state <= MUL;
`endif
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(XLEN-1)) begin
            rd_data_o <= fix_res(f3_q, acc_nxt, '0, '0, neg_res, neg_rem);
            rd_addr_o <= rd_q;
            rd_wen_o  <= 1'b1;
            state     <= DONE;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(XLEN-1)) begin
            rd_data_o <= fix_res(f3_q, '0, dvd_nxt, rem_nxt, neg_res, neg_rem);
            rd_addr_o <= rd_q;
            rd_wen_o  <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed cases, reset abort, back-to-back, randomized ops.
module tb_ex_muldiv;
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] inst_i, inst_addr_i, op_num1_i, op_num2_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i;
  logic        hold_flag_o, busy_o, rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  ex_muldiv u_dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op_num1_i(op_num1_i), .op_num2_i(op_num2_i), .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
    .hold_flag_o(hold_flag_o), .busy_o(busy_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; int lat; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, hold_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a)); sbv = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sbv; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sbv; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  task automatic nop();
    inst_i = 32'h00000013; reg_wen_i = 1'b0; rd_addr_i = '0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wen, input logic [6:0] f7);
    inst_i = {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    op_num1_i = a; op_num2_i = b; rd_addr_i = rd; reg_wen_i = wen;
    inst_addr_i = $urandom;
  endtask

  // called at a negedge with the DUT idle; op presented for one cycle then flushed
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic [4:0] rd, input logic wen,
                       input logic [6:0] f7);
    bit md;
    exp_t e;
    md = wen && (f7 == 7'd1);
    drive(f3, a, b, rd, wen, f7);
    if (md) begin
      e.rd = rd; e.data = exp_d; e.lat = lat_of(f3, a, b); e.cyc = cyc + e.lat;
      sb.push_back(e);
    end
    #1 chk("hold_start", {31'b0, hold_flag_o}, {31'b0, md});
    @(negedge clk);
    nop();
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    if (k == 100) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: busy_o still %b after %0d cycles", busy_o, k);
    end
  endtask

  // monitor: pops the scoreboard on every writeback strobe
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) hold_cnt = 0;
    else begin
      if (hold_flag_o) hold_cnt++;
      if (rd_wen_o) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: rd %0d data %h, none expected", rd_addr_o, rd_data_o);
        end else begin
          e = sb.pop_front();
          chk("wr_data", rd_data_o, e.data);
          chk("wr_rd", {27'b0, rd_addr_o}, {27'b0, e.rd});
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          chk("hold_cycles", 32'(hold_cnt), 32'(e.lat));
        end
        hold_cnt = 0;
      end
    end
  end

  logic [2:0]  d_f3  [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp [12] = '{32'hFFFFFFEB, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
  logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
    $fatal(1);
  end

  initial begin
    int t;
    exp_t e;
    logic [2:0]  f3;
    logic [31:0] a, b;
    nop(); op_num1_i = '0; op_num2_i = '0; inst_addr_i = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_hold", {31'b0, hold_flag_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_wen", {31'b0, rd_wen_o}, 32'd0);
    chk("rst_rd", {27'b0, rd_addr_o}, 32'd0);
    chk("rst_data", rd_data_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wait_idle();
      issue(d_f3[i], d_a[i], d_b[i], d_exp[i], 5'(i + 1), 1'b1, 7'd1);
    end

    // ignored encodings: plain ADD and a muldiv op without write enable
    wait_idle();
    issue(3'd0, 32'd3, 32'd4, 32'd0, 5'd20, 1'b1, 7'd0);
    wait_idle();
    issue(3'd4, 32'd9, 32'd3, 32'd0, 5'd21, 1'b0, 7'd1);

    // back-to-back: second DIV held at the inputs, taken only once IDLE
    wait_idle();
    t = cyc;
    drive(3'd4, 32'hFFFFFF9C, 32'd7, 5'd10, 1'b1, 7'd1);
    e.rd = 5'd10; e.data = ref_model(3'd4, 32'hFFFFFF9C, 32'd7); e.lat = 33; e.cyc = t + 33;
    sb.push_back(e);
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      drive(3'd4, 32'd1000, 32'hFFFFFFFD, 5'd11, 1'b1, 7'd1);
      #1;
      if (i == 33) chk("b2b_done_hold", {31'b0, hold_flag_o}, 32'd0);
      if (i == 34) begin
        chk("b2b_accept_hold", {31'b0, hold_flag_o}, 32'd1);
        e.rd = 5'd11; e.data = ref_model(3'd4, 32'd1000, 32'hFFFFFFFD); e.lat = 33; e.cyc = t + 67;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    nop();

    // reset mid-DIVU aborts with no write
    wait_idle();
    issue(3'd5, 32'hFFFFFFFF, 32'd3, 32'h55555555, 5'd7, 1'b1, 7'd1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("abort_wen", {31'b0, rd_wen_o}, 32'd0);
    chk("abort_data", rd_data_o, 32'd0);
    chk("abort_rd", {27'b0, rd_addr_o}, 32'd0);
    chk("abort_busy", {31'b0, busy_o}, 32'd0);
    chk("abort_hold", {31'b0, hold_flag_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle();
    issue(3'd0, 32'h12345678, 32'h9ABCDEF0, ref_model(3'd0, 32'h12345678, 32'h9ABCDEF0), 5'd9, 1'b1, 7'd1);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(0, 9));
      wait_idle();
      issue(f3, a, b, ref_model(f3, a, b), 5'($urandom_range(1, 31)), 1'b1, 7'd1);
    end

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
